seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 166 ++++++++++++++++
 tb/tb_seq_alu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Sequential ALU. Six single-cycle ops (add, sub, and, or, srl,
//             sra) plus a 32-step style shift-add unsigned multiply and a
//             restoring unsigned divide, one result bit per clock.
//  Revision : 1.0  initial release
// ============================================================================
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       ALUOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] hi
);

   // controller states
   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_mul  = 2'd1;
   localparam logic [1:0] c_div  = 2'd2;

   // opcodes
   localparam logic [2:0] c_op_addu  = 3'b000;
   localparam logic [2:0] c_op_subu  = 3'b001;
   localparam logic [2:0] c_op_and   = 3'b010;
   localparam logic [2:0] c_op_or    = 3'b011;
   localparam logic [2:0] c_op_srl   = 3'b100;
   localparam logic [2:0] c_op_sra   = 3'b101;
   localparam logic [2:0] c_op_multu = 3'b110;
   localparam logic [2:0] c_op_divu  = 3'b111;

   // iteration count at which the multi-cycle result is complete
   localparam logic [SHW:0] c_last = (SHW+1)'(WIDTH);

   logic [1:0]       r_state;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_a;      // multiplicand / single-cycle operand A
   logic [WIDTH-1:0] r_b;      // divisor / single-cycle operand B
   logic [WIDTH-1:0] r_acc;    // running high product / partial remainder
   logic [WIDTH-1:0] r_q;      // multiplier bits / dividend-to-quotient
   logic [SHW:0]     r_cnt;    // iterations completed in MUL/DIV
   logic             r_pend;   // single-cycle op captured, result due next edge
   logic             r_done;
   logic [WIDTH-1:0] r_c;
   logic [WIDTH-1:0] r_hi;

   logic [WIDTH-1:0] w_res;
   logic [WIDTH:0]   w_msum;
   logic [WIDTH:0]   w_dshift;
   logic [WIDTH-1:0] w_ddiff;
   logic             w_dge;

   // single-cycle result from the captured operands
   always_comb begin
      w_res = '0;
      case (r_op)
         c_op_addu: w_res = r_a + r_b;
         c_op_subu: w_res = r_a - r_b;
         c_op_and:  w_res = r_a & r_b;
         c_op_or:   w_res = r_a | r_b;
         c_op_srl:  w_res = r_a >> r_b[SHW-1:0];
         c_op_sra:  w_res = $unsigned($signed(r_a) >>> r_b[SHW-1:0]);
         default:   w_res = '0;
      endcase
   end

   // one multiply step: conditionally add multiplicand, then shift {acc,q} right
   always_comb begin
      w_msum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_a} : '0);
   end

   // one restoring-divide step; the difference only matters when it is
   // non-negative, and then it always fits in WIDTH bits
   always_comb begin
      w_dshift = {r_acc, r_q[WIDTH-1]};
      w_dge    = (w_dshift >= {1'b0, r_b});
      w_ddiff  = w_dshift[WIDTH-1:0] - r_b;
   end

   // controller and datapath; the first MUL/DIV cycle only loads operands,
   // so busy is held low there and rises once iterations begin
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_idle;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_q     <= '0;
         r_cnt   <= '0;
         r_pend  <= 1'b0;
         r_done  <= 1'b0;
         r_c     <= '0;
         r_hi    <= '0;
      end else begin
         r_done <= 1'b0;
         r_pend <= 1'b0;

         // retire a single-cycle op captured on the previous edge
         if (r_pend) begin
            r_c    <= w_res;
            r_done <= 1'b1;
         end

         case (r_state)
            c_idle: begin
               if (start) begin
                  r_op  <= ALUOp;
                  r_a   <= A;
                  r_b   <= B;
                  r_acc <= '0;
                  r_cnt <= '0;
                  r_q   <= (ALUOp == c_op_multu) ? B : A;
                  if (ALUOp == c_op_multu) begin
                     r_state <= c_mul;
                  end else if (ALUOp == c_op_divu) begin
                     r_state <= c_div;
                  end else begin
                     r_pend <= 1'b1;
                  end
               end
            end
            c_mul: begin
               if (r_cnt == c_last) begin
                  r_c     <= r_q;
                  r_hi    <= r_acc;
                  r_done  <= 1'b1;
                  r_state <= c_idle;
               end else begin
                  r_acc <= w_msum[WIDTH:1];
                  r_q   <= {w_msum[0], r_q[WIDTH-1:1]};
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            c_div: begin
               if (r_cnt == c_last) begin
                  r_c     <= r_q;
                  r_hi    <= r_acc;
                  r_done  <= 1'b1;
                  r_state <= c_idle;
               end else begin
                  r_acc <= w_dge ? w_ddiff : w_dshift[WIDTH-1:0];
                  r_q   <= {r_q[WIDTH-2:0], w_dge};
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= c_idle;
         endcase
      end
   end

   assign busy = (r_state != c_idle) && (r_cnt != '0);
   assign done = r_done;
   assign C    = r_c;
   assign hi   = r_hi;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_alu
//  Purpose  : Scoreboard bench for seq_alu (WIDTH=32) with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_alu;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  ALUOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [31:0] C;
   logic [31:0] hi;

   seq_alu #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .ALUOp (ALUOp),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .C     (C),
      .hi    (hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] c;
      logic [31:0] h;
      int          due;
      int          run;
      int          tag;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          run   = 0;
   int          ntag  = 0;
   logic [31:0] model_hi = '0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // monitor: pops the scoreboard on every done pulse
   always @(negedge clk) begin
      if (!reset) begin
         chk("busy_and_done", {31'd0, busy & done}, 32'd0);
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               $display("op#%0d done", e.tag);
               chk("C", C, e.c);
               chk("hi", hi, e.h);
               chk("done_cycle", cyc, e.due);
               chk("busy_cycles", run, e.run);
            end
         end
         if (busy) run++;
         else      run = 0;
      end else begin
         run = 0;
      end
   end

   // call at negedge+1; the accept edge is the next rising edge
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ec, input logic [31:0] eh, input bit multi);
      exp_t it;
      start = 1'b1;
      ALUOp = op;
      A     = a;
      B     = b;
      if (multi) model_hi = eh;
      it.c   = ec;
      it.h   = model_hi;
      it.due = cyc + 1 + (multi ? 33 : 1);
      it.run = multi ? 32 : 0;
      it.tag = ntag++;
      sb.push_back(it);
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   // wait until the scoreboard drains; returns at negedge+1 of the done cycle
   task automatic wait_done();
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0) return;
         @(negedge clk); #1;
      end
      chk("timeout_waiting_done", 32'd1, 32'd0);
      sb.delete();
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      ALUOp = 3'b000;
      A     = '0;
      B     = '0;
      repeat (2) @(negedge clk);
      chk("rst_C", C, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      #1 reset = 1'b0;

      // single-cycle ops, including wrap-around and back-to-back issue
      issue(3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b0);
      issue(3'b001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h0, 1'b0);
      issue(3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0);
      issue(3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 32'h0, 1'b0);
      issue(3'b101, 32'h80000000, 32'h00000024, 32'hF8000000, 32'h0, 1'b0);
      issue(3'b100, 32'h80000000, 32'h00000024, 32'h08000000, 32'h0, 1'b0);
      wait_done();

      // multiply, then a single-cycle op that must keep hi from the product
      issue(3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1);
      wait_done();
      issue(3'b000, 32'h00000001, 32'h00000002, 32'h00000003, 32'h0, 1'b0);
      wait_done();
      issue(3'b110, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 1'b1);
      wait_done();

      // divide with an ignored start during busy, then back-to-back divide
      issue(3'b111, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b1);
      repeat (5) @(negedge clk);
      #1;
      start = 1'b1; ALUOp = 3'b000; A = 32'd9; B = 32'd9;
      @(negedge clk); #1;
      start = 1'b0;
      wait_done();
      issue(3'b111, 32'hFFFFFFFF, 32'h0000000A, 32'h19999999, 32'h00000005, 1'b1);
      wait_done();

      // divide by zero
      issue(3'b111, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h00000007, 1'b1);
      wait_done();

      // asynchronous reset in the middle of a multiply
      issue(3'b110, 32'h00000003, 32'h00000005, 32'h0000000F, 32'h00000000, 1'b1);
      repeat (9) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("arst_C", C, 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      sb.delete();
      model_hi = '0;
      @(negedge clk); #1;
      reset = 1'b0;
      issue(3'b000, 32'h00000002, 32'h00000003, 32'h00000005, 32'h0, 1'b0);
      wait_done();

      // idle period: any stray done is flagged by the monitor
      repeat (40) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
